// File: rtl/fp_mul_reg.sv
// fp_mul_reg: registered 16-bit float multiplier (1/8/7 format, truncating, flush-to-zero), one-cycle latency.
module fp_mul_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [15:0] op_a_i,
  input  logic [15:0] op_b_i,
  output logic        valid_o,
  output logic [15:0] result_o
);
  logic        s, inc, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [7:0]  ea, eb;
  logic [6:0]  ma, mb, mant;
  logic [15:0] prod, res, result_d, result_q;
  logic signed [9:0] e;
  logic        valid_d, valid_q;
  always_comb begin
    s      = op_a_i[15] ^ op_b_i[15];
    ea     = op_a_i[14:7];
    eb     = op_b_i[14:7];
    ma     = op_a_i[6:0];
    mb     = op_b_i[6:0];
    a_zero = ea == 8'h00;
    b_zero = eb == 8'h00;
    a_inf  = ea == 8'hFF && ma == 7'd0;
    b_inf  = eb == 8'hFF && mb == 7'd0;
    a_nan  = ea == 8'hFF && ma != 7'd0;
    b_nan  = eb == 8'hFF && mb != 7'd0;
    prod   = 16'({1'b1, ma}) * 16'({1'b1, mb});
    inc    = prod[15];
    mant   = 7'(prod >> (inc ? 4'd8 : 4'd7));
    e      = $signed(10'(ea) + 10'(eb) + 10'(inc) - 10'd127);
    res    = (a_nan || b_nan)                       ? 16'h7FC0 :
             ((a_zero && b_inf) || (a_inf && b_zero)) ? 16'h7FC0 :
             (a_inf || b_inf)                       ? {s, 8'hFF, 7'd0} :
             (a_zero || b_zero)                     ? {s, 15'd0} :
             (e >= 10'sd255)                        ? {s, 8'hFF, 7'd0} :
             (e <= 10'sd0)                          ? {s, 15'd0} :
                                                      {s, e[7:0], mant};
    valid_d  = valid_i;
    result_d = valid_i ? res : result_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      result_q <= 16'h0000;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end
  assign valid_o  = valid_q;
  assign result_o = result_q;
endmodule

// File: tb/tb_fp_mul_reg.sv
// tb_fp_mul_reg: directed and model-checked random vectors for fp_mul_reg.
module tb_fp_mul_reg;
  logic        clk_i = 1'b0, rst_i = 1'b1, valid_i = 1'b0, valid_o;
  logic [15:0] op_a_i = 16'h0, op_b_i = 16'h0, result_o;
  int passed = 0, total = 0;

  fp_mul_reg dut (.clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .op_a_i(op_a_i),
                  .op_b_i(op_b_i), .valid_o(valid_o), .result_o(result_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b);
    valid_i = v;
    op_a_i  = a;
    op_b_i  = b;
    @(posedge clk_i);
    #1;
  endtask

  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    step(1'b1, a, b);
    chk({tag, "_v"}, 16'(valid_o), 16'h1);
    chk(tag, result_o, exp);
  endtask

  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic s;
    int ea, eb, ma, mb, p, e, m;
    bit za, zb, ia, ib;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]); eb = int'(b[14:7]);
    ma = int'(a[6:0]);  mb = int'(b[6:0]);
    za = ea == 0;   zb = eb == 0;
    ia = ea == 255 && ma == 0;
    ib = eb == 255 && mb == 0;
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0)) return 16'h7FC0;
    if ((za && ib) || (ia && zb)) return 16'h7FC0;
    if (ia || ib) return {s, 15'h7F80};
    if (za || zb) return {s, 15'h0};
    p = (128 + ma) * (128 + mb);
    e = ea + eb - 127;
    if (p >= 32768) begin
      e = e + 1;
      m = (p / 256) % 128;
    end else m = (p / 128) % 128;
    if (e >= 255) return {s, 15'h7F80};
    if (e <= 0) return {s, 15'h0};
    return {s, 8'(e), 7'(m)};
  endfunction

  initial begin
    logic [15:0] a, b;
    #1;
    chk("reset_v", 16'(valid_o), 16'h0);
    chk("reset_r", result_o, 16'h0000);
    @(negedge clk_i);
    rst_i = 1'b0;
    op("first", 16'h3FC0, 16'h4000, 16'h4040);
    valid_i = 1'b1; op_a_i = 16'h3FC0; op_b_i = 16'h3FC0;
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    chk("async_rst_v", 16'(valid_o), 16'h0);
    chk("async_rst_r", result_o, 16'h0000);
    @(negedge clk_i);
    rst_i = 1'b0;
    op("post_rst", 16'hC000, 16'h4040, 16'hC0C0);
    op("b2b_1", 16'h3FC0, 16'h4000, 16'h4040);
    op("b2b_2", 16'h3FC0, 16'h3FC0, 16'h4010);
    op("b2b_3", 16'hC000, 16'h4040, 16'hC0C0);
    op("trunc", 16'h3F81, 16'h3F81, 16'h3F82);
    op("one", 16'h3F80, 16'h3F80, 16'h3F80);
    op("ovf_p", 16'h7F00, 16'h4000, 16'h7F80);
    op("ovf_n", 16'hFF00, 16'h4000, 16'hFF80);
    op("unf_p", 16'h0080, 16'h3F00, 16'h0000);
    op("unf_n", 16'h8080, 16'h3F00, 16'h8000);
    op("zero_inf", 16'h0000, 16'h7F80, 16'h7FC0);
    op("inf_zero", 16'h7F80, 16'h8000, 16'h7FC0);
    op("nan", 16'h7FC1, 16'h3F80, 16'h7FC0);
    op("nan_inf", 16'h7F80, 16'hFF81, 16'h7FC0);
    op("inf_neg", 16'h7F80, 16'hBF80, 16'hFF80);
    op("negzero", 16'h8000, 16'h3F80, 16'h8000);
    op("denorm", 16'h0001, 16'h4000, 16'h0000);
    op("gate_1", 16'h4000, 16'h4000, 16'h4080);
    step(1'b0, 16'h4040, 16'h4040);
    chk("gate_2_v", 16'(valid_o), 16'h0);
    chk("gate_2_r", result_o, 16'h4080);
    step(1'b0, 16'h3F80, 16'hC000);
    chk("gate_3_v", 16'(valid_o), 16'h0);
    chk("gate_3_r", result_o, 16'h4080);
    op("gate_4", 16'h4040, 16'h4000, 16'h40C0);
    for (int i = 0; i < 10000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 8 == 1) a[14:7] = 8'hFF;
      if (i % 8 == 2) b[14:7] = 8'h00;
      if (i % 8 == 3) a[14:7] = 8'(96 + $urandom_range(0, 63));
      if (i % 8 == 3) b[14:7] = 8'(96 + $urandom_range(0, 63));
      op("rand", a, b, ref_mul(a, b));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
